// File: rtl/game_sequencer_pkg.sv
// Shared breakout definitions: FSM state encoding, default grid/lives constants and
// the playfield geometry that the block/ball datapath also uses.
package game_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_LOSE      = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    localparam int GRID_ROWS       = 5;
    localparam int GRID_COLS       = 12;
    localparam int NUM_BLOCKS_DEF  = GRID_ROWS * GRID_COLS;
    localparam int START_LIVES_DEF = 3;

    // Playfield walls and floor in 640x480 pixel coordinates
    localparam int WALL_LEFT_X  = 8;
    localparam int WALL_RIGHT_X = 631;
    localparam int WALL_TOP_Y   = 8;
    localparam int FLOOR_Y      = 471;

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Loadable down-counter advanced by frame_tick; done fires combinationally on the tick
// that takes the count from 1 to 0, so the FSM can act on that very frame.
module game_sequencer_frame_timer #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam int CW = $clog2(FRAMES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(FRAMES);

    logic [CW-1:0] count;

    assign done = tick && (count == CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (tick && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Breakout game-flow controller: Moore FSM sequencing grid reset, serve, play,
// life loss and end of game; owns lives, score and blocks_left.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int NUM_BLOCKS       = NUM_BLOCKS_DEF,
    parameter int START_LIVES      = START_LIVES_DEF,
    parameter int POINTS_PER_BLOCK = 10,
    parameter int SCORE_W          = 14,
    parameter int LOSE_FRAMES      = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               block_hit,
    input  logic               floor_hit,
    output logic [2:0]         state,
    output logic               grid_reset,
    output logic               ball_serve,
    output logic               phys_en,
    output logic               paddle_en,
    output logic [2:0]         lives,
    output logic [SCORE_W-1:0] score,
    output logic [5:0]         blocks_left
);

    localparam logic [SCORE_W:0] PTS      = (SCORE_W + 1)'(POINTS_PER_BLOCK);
    localparam logic [2:0]       LIVES0   = 3'(START_LIVES);
    localparam logic [5:0]       BLOCKS0  = 6'(NUM_BLOCKS);

    state_t st;
    logic   win_now;
    logic   timer_load;
    logic   timer_done;

    function automatic logic [SCORE_W-1:0] add_points(input logic [SCORE_W-1:0] a);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + PTS;
        return sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    endfunction

    // The last block wins over a simultaneous floor hit
    assign win_now    = (blocks_left == 6'd0) || (block_hit && (blocks_left == 6'd1));
    assign timer_load = (st == ST_PLAY) && floor_hit && !win_now;
    assign state      = st;

    game_sequencer_frame_timer #(
        .FRAMES (LOSE_FRAMES)
    ) u_lose_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .tick  (frame_tick),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= ST_INIT;
            grid_reset  <= 1'b0;
            ball_serve  <= 1'b0;
            phys_en     <= 1'b0;
            paddle_en   <= 1'b0;
            lives       <= LIVES0;
            score       <= '0;
            blocks_left <= BLOCKS0;
        end else begin
            grid_reset <= 1'b0;
            ball_serve <= 1'b0;
            phys_en    <= 1'b0;
            case (st)
                ST_INIT: begin
                    grid_reset  <= 1'b1;
                    ball_serve  <= 1'b1;
                    paddle_en   <= 1'b1;
                    lives       <= LIVES0;
                    score       <= '0;
                    blocks_left <= BLOCKS0;
                    st          <= ST_SERVE;
                end
                ST_SERVE: begin
                    paddle_en <= 1'b1;
                    if (start_btn) st <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (block_hit && (blocks_left != 6'd0)) begin
                        blocks_left <= blocks_left - 6'd1;
                        score       <= add_points(score);
                    end
                    if (win_now) begin
                        paddle_en <= 1'b0;
                        st        <= ST_WIN;
                    end else if (floor_hit) begin
                        if (lives != 3'd0) lives <= lives - 3'd1;
                        paddle_en <= 1'b0;
                        st        <= ST_LOSE;
                    end else begin
                        paddle_en <= 1'b1;
                        phys_en   <= frame_tick;
                    end
                end
                ST_LOSE: begin
                    paddle_en <= 1'b0;
                    if (timer_done) begin
                        if (lives == 3'd0) begin
                            st <= ST_GAME_OVER;
                        end else begin
                            ball_serve <= 1'b1;
                            paddle_en  <= 1'b1;
                            st         <= ST_SERVE;
                        end
                    end
                end
                ST_GAME_OVER, ST_WIN: begin
                    paddle_en <= 1'b0;
                    if (start_btn) st <= ST_INIT;
                end
                default: begin
                    paddle_en <= 1'b0;
                    st        <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer; a second instance with a 6-bit score exercises
// score saturation within the 60 blocks a single game offers.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        start_btn;
    logic        block_hit;
    logic        floor_hit;

    logic [2:0]  state;
    logic        grid_reset, ball_serve, phys_en, paddle_en;
    logic [2:0]  lives;
    logic [13:0] score;
    logic [5:0]  blocks_left;

    logic [2:0]  s_state;
    logic        s_grid_reset, s_ball_serve, s_phys_en, s_paddle_en;
    logic [2:0]  s_lives;
    logic [5:0]  s_score;
    logic [5:0]  s_blocks_left;

    int checks = 0;
    int errors = 0;
    int phys_cnt = 0;
    int phys_base;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .block_hit   (block_hit),
        .floor_hit   (floor_hit),
        .state       (state),
        .grid_reset  (grid_reset),
        .ball_serve  (ball_serve),
        .phys_en     (phys_en),
        .paddle_en   (paddle_en),
        .lives       (lives),
        .score       (score),
        .blocks_left (blocks_left)
    );

    game_sequencer #(.SCORE_W(6)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .block_hit   (block_hit),
        .floor_hit   (floor_hit),
        .state       (s_state),
        .grid_reset  (s_grid_reset),
        .ball_serve  (s_ball_serve),
        .phys_en     (s_phys_en),
        .paddle_en   (s_paddle_en),
        .lives       (s_lives),
        .score       (s_score),
        .blocks_left (s_blocks_left)
    );

    always @(negedge clk) if (phys_en) phys_cnt <= phys_cnt + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_frame();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
    endtask

    task automatic press_start();
        start_btn = 1'b1; step(); start_btn = 1'b0;
    endtask

    task automatic hit_block();
        block_hit = 1'b1; step(); block_hit = 1'b0;
    endtask

    task automatic hit_floor();
        floor_hit = 1'b1; step(); floor_hit = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick_frame();
            step();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " state"},  int'(state), 0);
        check({tag, " lives"},  int'(lives), 3);
        check({tag, " score"},  int'(score), 0);
        check({tag, " blocks"}, int'(blocks_left), 60);
        check({tag, " paddle"}, int'(paddle_en), 0);
        check({tag, " phys"},   int'(phys_en), 0);
        check({tag, " grid"},   int'(grid_reset), 0);
        check({tag, " serve"},  int'(ball_serve), 0);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
        block_hit = 1'b0; floor_hit = 1'b0;
        repeat (3) step();
        check_reset_values("rst");
        check("sat rst outs", int'({s_grid_reset, s_ball_serve, s_phys_en, s_paddle_en}), 0);
        check("sat rst state", int'(s_state), 0);

        // INIT -> SERVE with one grid_reset / ball_serve pulse
        rst_n = 1'b1;
        step();
        check("init->serve", int'(state), 1);
        check("grid pulse", int'(grid_reset), 1);
        check("serve pulse", int'(ball_serve), 1);
        check("serve paddle", int'(paddle_en), 1);
        check("serve phys", int'(phys_en), 0);
        step();
        check("grid 1 wide", int'(grid_reset), 0);
        check("serve 1 wide", int'(ball_serve), 0);

        // Hits and frames are ignored in SERVE
        hit_block(); hit_floor(); tick_frame();
        check("serve phys ignore", int'(phys_en), 0);
        check("serve score", int'(score), 0);
        check("serve blocks", int'(blocks_left), 60);
        check("serve lives", int'(lives), 3);
        check("serve state", int'(state), 1);

        // start and frame_tick together: PLAY, but no phys_en for that tick
        phys_base = phys_cnt;
        start_btn = 1'b1; frame_tick = 1'b1; step(); start_btn = 1'b0; frame_tick = 1'b0;
        check("play state", int'(state), 2);
        check("no phys on start tick", int'(phys_en), 0);
        step();
        check("no phys after start tick", int'(phys_en), 0);
        for (int i = 0; i < 3; i++) begin
            tick_frame();
            check("phys after tick", int'(phys_en), 1);
            step();
            check("phys 1 wide", int'(phys_en), 0);
            step();
        end
        check("phys count", phys_cnt - phys_base, 3);

        press_start();
        check("start ignored in play", int'(state), 2);

        for (int i = 0; i < 5; i++) hit_block();
        check("score 5 hits", int'(score), 50);
        check("blocks 5 hits", int'(blocks_left), 55);
        check("sat score 50", int'(s_score), 50);
        hit_block();
        check("sat score 60", int'(s_score), 60);
        hit_block();
        check("sat score clamp", int'(s_score), 63);
        check("score 70", int'(score), 70);
        hit_block();
        check("sat score holds", int'(s_score), 63);
        check("score 80", int'(score), 80);
        check("blocks 52", int'(blocks_left), 52);
        check("sat blocks 52", int'(s_blocks_left), 52);

        // Life loss and LOSE delay
        hit_floor();
        check("lose state", int'(state), 3);
        check("lose lives", int'(lives), 2);
        check("lose paddle", int'(paddle_en), 0);
        press_start();
        check("start ignored in lose", int'(state), 3);
        frames(59);
        check("still lose @59", int'(state), 3);
        check("no serve @59", int'(ball_serve), 0);
        tick_frame();
        check("reserve state", int'(state), 1);
        check("reserve pulse", int'(ball_serve), 1);
        check("reserve paddle", int'(paddle_en), 1);
        step();
        check("reserve 1 wide", int'(ball_serve), 0);

        press_start(); hit_floor(); frames(60);
        check("lives 1", int'(lives), 1);
        check("serve again", int'(state), 1);
        press_start(); hit_floor();
        check("lives 0", int'(lives), 0);
        frames(59);
        tick_frame();
        check("game over", int'(state), 4);
        check("go no serve", int'(ball_serve), 0);
        check("go paddle", int'(paddle_en), 0);
        hit_block(); hit_floor(); tick_frame(); step();
        check("go score frozen", int'(score), 80);
        check("go blocks frozen", int'(blocks_left), 52);
        check("go lives frozen", int'(lives), 0);
        check("go phys", int'(phys_en), 0);
        check("go state", int'(state), 4);
        check("sat go lives", int'(s_lives), 0);

        // New game
        press_start();
        check("restart init", int'(state), 0);
        step();
        check("restart serve", int'(state), 1);
        check("restart lives", int'(lives), 3);
        check("restart score", int'(score), 0);
        check("restart blocks", int'(blocks_left), 60);
        check("restart grid", int'(grid_reset), 1);

        // Clear all 60 blocks
        press_start();
        for (int i = 0; i < 59; i++) hit_block();
        check("blocks 1", int'(blocks_left), 1);
        check("not won yet", int'(state), 2);
        hit_block();
        check("win state", int'(state), 5);
        check("win blocks", int'(blocks_left), 0);
        check("win score", int'(score), 600);
        check("sat win score", int'(s_score), 63);
        check("sat win state", int'(s_state), 5);
        hit_floor(); hit_block();
        check("win lives", int'(lives), 3);
        check("win blocks frozen", int'(blocks_left), 0);

        // Last block and floor in the same cycle
        press_start(); step(); press_start();
        for (int i = 0; i < 59; i++) hit_block();
        block_hit = 1'b1; floor_hit = 1'b1; step(); block_hit = 1'b0; floor_hit = 1'b0;
        check("tie win", int'(state), 5);
        check("tie lives", int'(lives), 3);
        check("tie blocks", int'(blocks_left), 0);
        check("tie score", int'(score), 600);

        // Reset in the middle of a LOSE delay
        press_start(); step(); press_start(); hit_floor();
        frames(30);
        check("mid lose", int'(state), 3);
        rst_n = 1'b0; frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_reset_values("mid rst");
        rst_n = 1'b1;
        step();
        check("post rst serve", int'(state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the breakout design: a Moore FSM that sequences grid reset, serve, play, life-loss and end-of-game.
- Gates the per-frame physics update (ball/paddle motion and collision) to PLAY only; owns lives, score and blocks-remaining counters.
- Sits between the VGA timing/debounce logic (frame_tick, start_btn) and the block/ball datapath (grid_reset, ball_serve, phys_en, paddle_en).

Parameters:
- NUM_BLOCKS, 60, blocks in grid (5 rows x 12 cols); reload value of blocks_left
- START_LIVES, 3, lives loaded on grid reset; must be 1..7
- POINTS_PER_BLOCK, 10, score increment per destroyed block
- SCORE_W, 14, score width; score saturates at 2^SCORE_W-1
- LOSE_FRAMES, 60, frames spent in LOSE before re-serve (1 s at 60 Hz); must be >=1

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (end of active area)
- start_btn  in  1  debounced one-cycle launch/restart pulse
- block_hit  in  1  one-cycle pulse per newly destroyed block (never for an already-hit block)
- floor_hit  in  1  one-cycle pulse when ball reaches FLOOR_Y
- state  out  3  current FSM state (encoding in shared header)
- grid_reset  out  1  one-cycle pulse: datapath clears all block hit bits
- ball_serve  out  1  one-cycle pulse: datapath reloads ball above paddle, velocity (+2,-2)
- phys_en  out  1  one-cycle pulse per frame while PLAY; the only enable for ball motion and collision
- paddle_en  out  1  level: paddle may move (SERVE and PLAY)
- lives  out  3  remaining lives
- score  out  SCORE_W  accumulated score
- blocks_left  out  6  blocks not yet destroyed

Behaviour:
- Reset (rst_n=0 at posedge): state=INIT, grid_reset=0, ball_serve=0, phys_en=0, paddle_en=0, lives=START_LIVES, score=0, blocks_left=NUM_BLOCKS, frame counter=0. Takes effect from any state, including mid-LOSE; pending pulses dropped.
- States: INIT, SERVE, PLAY, LOSE, GAME_OVER, WIN.
- INIT: one cycle. Pulses grid_reset and ball_serve, reloads lives/score/blocks_left, then -> SERVE.
- SERVE: paddle_en=1, no phys_en. start_btn -> PLAY.
- PLAY: paddle_en=1. phys_en is registered, high exactly one cycle after each frame_tick. block_hit: blocks_left-1, score+POINTS_PER_BLOCK (saturating). floor_hit: lives-1, -> LOSE.
- blocks_left reaching 0 in PLAY -> WIN on next cycle. WIN beats LOSE when block_hit and floor_hit coincide: the block is counted, no life is lost.
- LOSE: paddle_en=0. Counts frame_ticks. On the LOSE_FRAMES-th tick: lives==0 -> GAME_OVER; otherwise pulse ball_serve and -> SERVE.
- GAME_OVER / WIN: all enables low, counters frozen. start_btn -> INIT (new game).
- block_hit, floor_hit and start_btn are ignored in every state other than those listed above, including start_btn while in PLAY or LOSE.
- blocks_left never decrements below 0. lives never decrements below 0; floor_hit is ignored outside PLAY.
- frame_tick and start_btn in the same cycle in SERVE: the transition to PLAY happens, but no phys_en for that tick. The first phys_en follows the next frame_tick.
- All outputs are registered. Output pulses are exactly one clk wide.

Decomposition:
- Shared header game_defs.vh: state encodings (INIT=0, SERVE=1, PLAY=2, LOSE=3, GAME_OVER=4, WIN=5); NUM_BLOCKS, START_LIVES and the wall/floor coordinates shared with the block/ball datapath.
- One sub-module, game_frame_timer: loadable down-counter clocked by frame_tick, with a done pulse. Used for the LOSE delay.
- Score, lives and blocks_left counters stay inline.

Test Plan:
- Reset then start_btn: INIT pulses grid_reset and ball_serve once -> SERVE (paddle_en=1, phys_en=0). start_btn -> PLAY; 3 frame_ticks -> exactly 3 phys_en pulses, each 1 cycle after its tick.
- In PLAY, 5 block_hit pulses -> score=50, blocks_left=55. Force score to 16380 and apply 1 hit -> score=16383 (saturated).
- floor_hit with lives=3 -> lives=2, state LOSE, paddle_en=0. 59 frame_ticks -> still LOSE. 60th tick -> ball_serve pulse, state SERVE.
- Three floor_hits, each followed by the LOSE delay -> lives=0, state GAME_OVER, score frozen. start_btn -> INIT, then lives=3, score=0, blocks_left=60.
- 60 block_hits -> WIN. Separately, with blocks_left=1, apply block_hit and floor_hit in the same cycle -> WIN, lives unchanged.
- Assert rst_n=0 during LOSE frame 30 -> next cycle state=INIT, all outputs at reset values. Also check block_hit/floor_hit in SERVE and GAME_OVER have no effect.
